// File: rtl/fifo_burst_reader_if.sv
// Bus bundle for fifo_burst_reader: the fifo pop port on one side and the
// valid/ready burst stream toward the host DMA on the other.
// master: the burst reader. slave: the fifo plus the stream consumer.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_SIZE  = 1024
);
  localparam int FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE);

  // fifo pop port
  logic [DATA_WIDTH-1:0]      fifo_data;
  logic                       fifo_rdy;
  logic [FIFO_SIZE_WIDTH-1:0] fifo_size;
  logic                       fifo_pop;

  // host stream
  logic [DATA_WIDTH-1:0]      m_data;
  logic                       m_valid;
  logic                       m_ready;
  logic                       m_last;

  modport master (
    input  fifo_data, fifo_rdy, fifo_size, m_ready,
    output fifo_pop, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_data, fifo_rdy, fifo_size, m_ready,
    input  fifo_pop, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains the attached fifo into framed bursts on a
// valid/ready stream. Each burst is a header word {8'hA5, seq_num, len}
// followed by len data words, m_last marking the final one.
// Optional feature macro: FIFO_BURST_READER_TIMEOUT_FLUSH_EN -- when defined,
// a fifo holding fewer than BURST_LEN words is flushed as a partial burst
// after TIMEOUT_CYCLES idle cycles.
module fifo_burst_reader #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_SIZE      = 1024,
  parameter int BURST_LEN      = 256,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  fifo_burst_reader_if.master bus,
  output logic                busy,
  output logic [7:0]          seq_num
);
  localparam int FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE);
  localparam logic [FIFO_SIZE_WIDTH-1:0] BURST_LEN_SZ = FIFO_SIZE_WIDTH'(BURST_LEN);
  localparam logic [15:0]                BURST_LEN_16 = 16'(BURST_LEN);
  localparam logic [7:0]                 HDR_TAG      = 8'hA5;

  // Reject parameter sets the framing cannot represent.
  if (DATA_WIDTH < 32 || BURST_LEN < 1 || BURST_LEN >= FIFO_SIZE ||
      TIMEOUT_CYCLES < 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("fifo_burst_reader: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_next;
  logic [15:0] count_q;      // data words still to pop in this burst
  logic        slot_free;    // output register may take a new word
  logic        start_full;
  logic        start_part;
  logic        start;
  logic        pop;
  logic        finish;
  logic [15:0] start_len;

  assign slot_free  = ~bus.m_valid | bus.m_ready;
  assign start_full = slot_free & enable & (bus.fifo_size >= BURST_LEN_SZ);
  // A full burst always wins; otherwise a timeout burst carries whatever is queued.
  assign start_len  = start_full ? BURST_LEN_16 : 16'(bus.fifo_size);

`ifdef FIFO_BURST_READER_TIMEOUT_FLUSH_EN
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  logic [15:0] idle_cnt_q;
  logic        partial_wait;

  assign partial_wait = enable & bus.fifo_rdy & (bus.fifo_size < BURST_LEN_SZ);
  assign start_part   = slot_free & partial_wait & ~start_full &
                        (idle_cnt_q == TIMEOUT_VAL);

  // Count consecutive idle cycles spent waiting on an under-filled fifo.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt_q <= '0;
    end else if (state_q != IDLE || start || !partial_wait) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != TIMEOUT_VAL) begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end
`else
  assign start_part = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // together from the values seen before the edge.
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_next;
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_next = state_q;
    start      = 1'b0;
    pop        = 1'b0;
    finish     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_full | start_part) begin
          start      = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        pop = bus.fifo_rdy & slot_free;
        if (pop && count_q == 16'd1) state_next = DRAIN;
      end
      DRAIN: begin
        // m_valid is always set here: the last data word is in the register.
        if (bus.m_ready) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output register, burst countdown and sequence number.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.m_data  <= '0;
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      count_q     <= '0;
      seq_num     <= '0;
    end else if (start) begin
      bus.m_data  <= DATA_WIDTH'({HDR_TAG, seq_num, start_len});
      bus.m_valid <= 1'b1;
      bus.m_last  <= 1'b0;
      count_q     <= start_len;
    end else if (pop) begin
      bus.m_data  <= bus.fifo_data;
      bus.m_valid <= 1'b1;
      bus.m_last  <= (count_q == 16'd1);
      count_q     <= count_q - 16'd1;
    end else if (finish) begin
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      seq_num     <= seq_num + 8'd1;
    end else if (bus.m_ready) begin
      // Word accepted with nothing to replace it (fifo stall).
      bus.m_valid <= 1'b0;
    end
  end

  assign bus.fifo_pop = pop;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side drain engine for the sample `fifo`. It pops words from the fifo's head and emits them on a valid/ready stream toward the host DMA. Output is framed as bursts: one header word, then `BURST_LEN` data words, with `m_last` on the final word. It sits between the fifo pop port and the host interface, and shares `clk`/`rstn` with the fifo.

## Interface
- `DATA_WIDTH`, 32: width of fifo and stream words; must be ≥ 32.
- `FIFO_SIZE`, 1024: depth of the attached fifo. `FIFO_SIZE_WIDTH` = $clog2(FIFO_SIZE) (localparam).
- `BURST_LEN`, 256: data words per full burst; range 1 to FIFO_SIZE-1.
- `TIMEOUT_CYCLES`, 1000: idle cycles before a partial flush (used only with the macro); width 16.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `enable` in 1: permits starting new bursts.
- `fifo_data` in DATA_WIDTH: fifo head word (combinational from the fifo).
- `fifo_rdy` in 1: fifo non-empty.
- `fifo_size` in FIFO_SIZE_WIDTH: fifo occupancy.
- `fifo_pop` out 1: pop strobe; drives the fifo's `out_data_vld`.
- `m_data` out DATA_WIDTH: stream word.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `m_last` out 1: final word of a burst.
- `busy` out 1: high in any state other than IDLE.
- `seq_num` out 8: sequence number of the current or next burst.

## Operation
- The design has one output register (`m_data`/`m_valid`/`m_last`). A word transfers on any cycle with `m_valid & m_ready`.
- "Slot free" means `~m_valid | m_ready`.
- States are IDLE, DATA and DRAIN.
- **IDLE**
  - A burst starts when `enable & (fifo_size >= BURST_LEN)` and the slot is free.
  - On start, the header is loaded, `len` is latched as BURST_LEN, the countdown is set to `len`, and the state goes to DATA.
- **Header format**
  - Bits [31:24] = 8'hA5, [23:16] = `seq_num`, [15:0] = `len`. Bits above 31 are zero.
  - `m_last` = 0 on the header.
- **DATA**
  - `fifo_pop = fifo_rdy & slot free`.
  - On a pop, `m_data` is loaded with `fifo_data` and the countdown decrements.
  - On the pop with countdown = 1, `m_last` is set to 1 and the state goes to DRAIN.
  - If `fifo_rdy` is low, the block stalls with no pop. `m_valid` clears once the current word is accepted.
- **DRAIN**
  - No pops.
  - When the last word is accepted: `m_valid` → 0, `m_last` → 0, `seq_num` increments (wraps 255 → 0), and the state goes to IDLE.
- `fifo_pop` is 0 outside DATA. It is never asserted while `fifo_rdy` = 0, so the fifo never underruns.
- Deasserting `enable` mid-burst has no effect: the burst completes. `enable` is only sampled in IDLE.
- Countdown width is 16 bits. `len` never exceeds FIFO_SIZE-1.

## Timing
- Reset values: `m_valid` 0, `m_data` 0, `m_last` 0, `busy` 0, `seq_num` 0, state IDLE, `fifo_pop` 0.
- An asynchronous reset mid-burst aborts the burst immediately. No partial tail is emitted after reset.
- Latency:
  - The start condition true at edge N gives the header with `m_valid` = 1 after edge N.
  - The first data word appears after edge N+1 if `m_ready` = 1 during the header cycle.
- Throughput: one word per cycle while `m_ready` = 1 and `fifo_rdy` = 1.
- A full burst with `m_ready` held high occupies BURST_LEN+1 valid cycles.
- There is exactly one cycle with `m_valid` = 0 between back-to-back bursts, because DRAIN returns to IDLE before the next start.
- `m_data`/`m_last` hold stable while `m_valid & ~m_ready`.

## Configuration
- Macro: `FIFO_BURST_READER_TIMEOUT_FLUSH_EN`.
- **Defined:**
  - In IDLE, a 16-bit counter counts cycles with `enable & fifo_rdy & (fifo_size < BURST_LEN)`. It clears on any other IDLE cycle and whenever a burst starts.
  - When the counter reaches TIMEOUT_CYCLES, a partial burst starts with `len` = current `fifo_size`. The header carries that `len`.
  - A full-burst condition takes priority over the timeout.
- **Undefined:** the counter is absent, only full bursts are emitted, and words below BURST_LEN remain in the fifo indefinitely.

## Test plan
- Reset, then `enable` = 1 with the fifo pushed 256 words 0..255 and `m_ready` = 1 → header 32'hA500_0100, then data 0..255 on 256 consecutive cycles, `m_last` on 255, `seq_num` → 1, fifo `fifo_size` → 0.
- 512 words pushed, `m_ready` = 1 → two bursts with headers 32'hA500_0100 and 32'hA501_0100, exactly one invalid cycle between them, and no fifo `event_underrun`.
- Toggle `m_ready` randomly (50%) during a burst → `m_data` stable whenever `m_valid & ~m_ready`, the word sequence is unbroken, and there is exactly one `m_last`.
- Assert `rstn` = 0 mid-burst at word 100, then push 256 words → `m_valid` drops asynchronously, the next header is 32'hA500_0100 (`seq_num` 0), and no stale words are emitted.
- With the macro defined, push 10 words and wait TIMEOUT_CYCLES = 1000 → header 32'hA500_000A, 10 data words with `m_last` on the 10th. With the macro undefined, the same stimulus gives `m_valid` = 0 indefinitely.
- `enable` = 0 with 300 words queued → no output and `busy` = 0. Drop `enable` mid-burst → the burst finishes its 256 words, then the block idles.
